// File: rtl/qsys_multi_timer.sv
// qsys_multi_timer: multi-channel down-counting interval timer on an Avalon-MM slave.
// Each channel owns a counter, PERIOD, CONTROL {STOP,START,CONT,ITO}, SNAP and a
// sticky TO flag. Timeout events come from a registered rising edge of counter==0.
// Optional feature macro: QSYS_MULTI_TIMER_PRESCALER_EN adds an 8-bit PRESCALE
// register per channel at reg 4 (count enable once every PRESCALE+1 clocks).
// Bus handshake: a write is chipselect & ~write_n, sampled on the rising clk edge.
// readdata is registered every cycle from address, one cycle of latency, and reads
// have no side effects.
module qsys_multi_timer #(
  parameter int          CHANNELS     = 4,
  parameter int          CNT_W        = 32,
  parameter logic [31:0] RESET_PERIOD = 32'h7A11F,
  localparam int         CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CH_W+2:0]     address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic                irq,
  output logic [CHANNELS-1:0] irq_vec,
  output logic [CHANNELS-1:0] tick
);

  logic            w_wr;
  logic [CH_W-1:0] w_ch;
  logic [2:0]      w_reg;
  logic [31:0]     w_rd_ch [CHANNELS];
  logic [31:0]     w_rd_mux;

  assign w_wr  = chipselect & ~write_n;
  assign w_ch  = address[CH_W+2:3];
  assign w_reg = address[2:0];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic             w_sel;
    logic             w_wr_status, w_wr_ctl, w_wr_period, w_wr_snap;
    logic             w_zero, w_event, w_en, w_start, w_stop;
    logic [31:0]      w_pre_rd;
    logic [31:0]      w_rdv;
    logic [CNT_W-1:0] r_cnt, r_period, r_snap;
    logic [3:0]       r_ctl;
    logic             r_run, r_to, r_zero_d, r_force, r_tick;

    assign w_sel       = w_wr && (w_ch == CH_W'(i));
    assign w_wr_status = w_sel && (w_reg == 3'd0);
    assign w_wr_ctl    = w_sel && (w_reg == 3'd1);
    assign w_wr_period = w_sel && (w_reg == 3'd2);
    assign w_wr_snap   = w_sel && (w_reg == 3'd3);
    assign w_start     = w_wr_ctl & writedata[2];
    assign w_stop      = w_wr_ctl & writedata[3];
    assign w_zero      = (r_cnt == '0);
    assign w_event     = w_zero & ~r_zero_d;

`ifdef QSYS_MULTI_TIMER_PRESCALER_EN
    logic       w_wr_pre;
    logic [7:0] r_pre, r_pcnt;

    assign w_wr_pre = w_sel && (w_reg == 3'd4);
    assign w_en     = (r_pcnt == r_pre);
    assign w_pre_rd = {24'b0, r_pre};

    // Prescale register and divider; divider restarts on START or forced reload
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_pre  <= 8'd0;
        r_pcnt <= 8'd0;
      end else begin
        if (w_wr_pre) r_pre <= writedata[7:0];
        if (w_start || r_force || w_en) r_pcnt <= 8'd0;
        else                            r_pcnt <= r_pcnt + 8'd1;
      end
    end
`else
    assign w_en     = 1'b1;
    assign w_pre_rd = 32'd0;
`endif

    // Channel state: counter, RUN, sticky TO, registered tick and bus registers
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt    <= CNT_W'(RESET_PERIOD);
        r_period <= CNT_W'(RESET_PERIOD);
        r_snap   <= '0;
        r_ctl    <= 4'd0;
        r_run    <= 1'b0;
        r_to     <= 1'b0;
        r_zero_d <= (CNT_W'(RESET_PERIOD) == '0);
        r_force  <= 1'b0;
        r_tick   <= 1'b0;
      end else begin
        r_force  <= w_wr_period;
        r_zero_d <= w_zero;
        r_tick   <= w_event;
        if (w_wr_period) r_period <= writedata[CNT_W-1:0];
        if (w_wr_ctl)    r_ctl    <= writedata[3:0];
        if (w_wr_snap)   r_snap   <= r_cnt;
        // clearing write beats a simultaneous timeout event
        if (w_wr_status)  r_to <= 1'b0;
        else if (w_event) r_to <= 1'b1;
        // START beats STOP and the forced reload so a back-to-back restart is not lost
        if (w_start)                        r_run <= 1'b1;
        else if (w_stop || r_force)         r_run <= 1'b0;
        else if (w_zero && !r_ctl[1])       r_run <= 1'b0;
        // one-shot channels hold at zero instead of reloading
        if (r_force)
          r_cnt <= r_period;
        else if (r_run && w_en && !(w_zero && !r_ctl[1]))
          r_cnt <= w_zero ? r_period : r_cnt - CNT_W'(1);
      end
    end

    // Per-channel read mux
    always_comb begin
      w_rdv = 32'd0;
      case (w_reg)
        3'd0:    w_rdv = {30'b0, r_run, r_to};
        3'd1:    w_rdv = {28'b0, r_ctl};
        3'd2:    w_rdv = 32'(r_period);
        3'd3:    w_rdv = 32'(r_snap);
        3'd4:    w_rdv = w_pre_rd;
        default: w_rdv = 32'd0;
      endcase
    end

    assign w_rd_ch[i] = w_rdv;
    assign tick[i]    = r_tick;
    assign irq_vec[i] = r_to & r_ctl[0];
  end

  // Channel select for reads; indexes beyond CHANNELS read zero
  always_comb begin
    w_rd_mux = 32'd0;
    for (int j = 0; j < CHANNELS; j++) begin
      if (w_ch == CH_W'(j)) w_rd_mux = w_rd_ch[j];
    end
  end

  // Registered read data, sampled every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= 32'd0;
    else       readdata <= w_rd_mux;
  end

  assign irq = |irq_vec;

endmodule

// File: tb/tb_qsys_multi_timer.sv
// Bench for qsys_multi_timer with two 32-bit channels.
module tb_qsys_multi_timer;
  localparam int CHANNELS = 2;
  localparam int CNT_W    = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  address = 4'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        irq;
  logic [1:0]  irq_vec;
  logic [1:0]  tick;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  // clock
  always #5 clk = ~clk;

  qsys_multi_timer #(.CHANNELS(CHANNELS), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq(irq), .irq_vec(irq_vec), .tick(tick)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // drivers: called right after a falling edge, return after the next falling edge
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
    address = a;
    exp_q.push_back(exp);
    @(negedge clk);
    check_eq(tag, readdata, exp_q.pop_front());
  endtask

  task automatic wait_tick(input int ch, input int max_n, output int n);
    n = 0;
    while (tick[ch] !== 1'b1 && n < max_n) begin
      @(negedge clk);
      n++;
    end
    if (n >= max_n) check_eq("tick_seen", 32'(tick[ch]), 32'd1);
  endtask

  task automatic check_interval(input string tag, input int ch, input int exp, input int max_n);
    int n;
    exp_q.push_back(32'(exp));
    wait_tick(ch, max_n, n);
    @(negedge clk);
    wait_tick(ch, max_n, n);
    check_eq(tag, 32'(n + 1), exp_q.pop_front());
  endtask

  task automatic count_ticks(input int ch, input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (tick[ch] === 1'b1) cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, p;
    // reset, then reset again while ch0 is counting
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus_write(4'd1, 32'h7);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_readdata", readdata, 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_tick", 32'(tick), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus_read("rst_status", 4'd0, 32'd0);
    bus_read("rst_control", 4'd1, 32'd0);
    bus_read("rst_period0", 4'd2, 32'h7A11F);
    bus_read("rst_snap", 4'd3, 32'd0);
    bus_read("rst_period1", 4'd10, 32'h7A11F);
    bus_read("unused_reg6", 4'd6, 32'd0);

    // continuous ch0, PERIOD=9, ITO
    bus_write(4'd2, 32'd9);
    bus_write(4'd1, 32'h7);
    check_interval("cont_interval", 0, 10, 40);
    check_eq("cont_irq", 32'(irq), 32'd1);
    check_eq("cont_irq_vec", 32'(irq_vec), 32'd1);
    @(negedge clk);
    check_eq("tick_width", 32'(tick[0]), 32'd0);
    bus_read("cont_status", 4'd0, 32'd3);
    bus_write(4'd0, 32'd0);
    check_eq("clr_irq", 32'(irq), 32'd0);
    bus_write(4'd1, 32'h8);
    bus_write(4'd0, 32'd0);

    // one-shot ch1, PERIOD=4, no ITO
    bus_write(4'd10, 32'd4);
    bus_write(4'd9, 32'h4);
    exp_q.push_back(32'd5);
    wait_tick(1, 40, n);
    check_eq("oneshot_latency", 32'(n), exp_q.pop_front());
    repeat (3) @(negedge clk);
    bus_read("oneshot_status", 4'd8, 32'd1);
    check_eq("oneshot_irq_vec", 32'(irq_vec), 32'd0);
    check_eq("oneshot_irq", 32'(irq), 32'd0);
    bus_write(4'd11, 32'd0);
    bus_read("oneshot_snap", 4'd11, 32'd0);
    count_ticks(1, 20, cnt);
    check_eq("oneshot_no_repeat", 32'(cnt), 32'd0);

    // STATUS clear on the same edge as the timeout event
    bus_write(4'd2, 32'd9);
    bus_write(4'd1, 32'h7);
    repeat (9) @(negedge clk);
    bus_write(4'd0, 32'd0);
    check_eq("race_tick", 32'(tick[0]), 32'd1);
    check_eq("race_irq_vec", 32'(irq_vec), 32'd0);
    bus_read("race_status", 4'd0, 32'd2);
    bus_write(4'd2, 32'd50);
    bus_write(4'd0, 32'd0);
    bus_read("reload_status", 4'd0, 32'd0);
    bus_write(4'd1, 32'hC);
    bus_read("startstop_status", 4'd0, 32'd2);
    bus_read("startstop_ctl", 4'd1, 32'hC);

    // snapshot mid-count and PERIOD write mid-run
    bus_write(4'd2, 32'd100);
    bus_write(4'd1, 32'h6);
    repeat (43) @(negedge clk);
    bus_write(4'd3, 32'd0);
    bus_read("snap57", 4'd3, 32'd57);
    bus_write(4'd2, 32'd200);
    @(negedge clk);
    bus_read("midrun_status", 4'd0, 32'd0);
    bus_write(4'd3, 32'd0);
    bus_read("midrun_cnt", 4'd3, 32'd200);

    // random continuous periods
    for (int it = 0; it < 3; it++) begin
      p = $urandom_range(1, 12);
      bus_write(4'd2, 32'(p));
      bus_write(4'd1, 32'h6);
      check_interval("rand_interval", 0, p + 1, 60);
    end
    bus_write(4'd1, 32'h8);

    // PERIOD=0: a single event, no repeats
    bus_write(4'd2, 32'd5);
    bus_write(4'd2, 32'd0);
    bus_write(4'd1, 32'h6);
    wait_tick(0, 10, n);
    count_ticks(0, 30, cnt);
    check_eq("p0_repeat", 32'(cnt), 32'd0);
    bus_write(4'd1, 32'h8);

    // prescaler
`ifdef QSYS_MULTI_TIMER_PRESCALER_EN
    bus_write(4'd12, 32'd3);
    bus_read("pre_read", 4'd12, 32'd3);
    bus_write(4'd10, 32'd4);
    bus_write(4'd9, 32'h6);
    check_interval("pre_interval", 1, 20, 100);
`else
    bus_write(4'd12, 32'd3);
    bus_read("pre_read", 4'd12, 32'd0);
    bus_write(4'd10, 32'd4);
    bus_write(4'd9, 32'h6);
    check_interval("pre_interval", 1, 5, 100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
